decoder_3x8_hs: RTL and testbench
=================================

// Module: decoder_3x8_hs
// PURPOSE
//  Registered 3:8 decoder with valid/ready input handshake and per-grant acknowledge.
//  It consumes the code Y and valid flag Vld produced by the 8:3 priority encoder.
//  It drives the one-hot line D[Y] until the selected requester acknowledges or a timeout expires.
//  It sits at the return side of the request/grant path: the encoder picks, this block grants.
// PARAMETERS
//  N        3    code width; output width is 2**N (8 at default)
//  TIMEOUT  16   max DRIVE cycles without Ack before forced release; legal range 2..255
// PORTS
//  clk   in   1     rising-edge clock
//  rst   in   1     synchronous reset, active-high
//  Y     in   N     encoded line index to grant
//  Vld   in   1     Y valid; a transfer occurs on an edge where Vld && Rdy
//  Rdy   out  1     block can accept a new code (registered)
//  D     out  2**N  one-hot grant; D[i]=1 iff granting code i (registered)
//  Ack   in   1     requester acknowledge for the current grant
//  Busy  out  1     high while in DRIVE
//  Done  out  1     1-cycle pulse: grant closed by Ack
//  Tout  out  1     1-cycle pulse: grant closed by timeout
//  Last  out  N     code of the most recently closed grant (Ack or timeout)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; D=0, Rdy=0, Busy=0, Done=0, Tout=0, Last=0, cnt=0.
//   - Rdy rises on the first edge with rst=0. rst in DRIVE aborts the grant: D=0 next cycle, no Done/Tout.
//  States: IDLE, DRIVE. All outputs are registered; no combinational path from inputs to outputs.
//  IDLE:
//   - Rdy=1, D=0, Busy=0.
//   - Edge with Vld=1: capture Y; next cycle state=DRIVE, D=1<<Y, Rdy=0, Busy=1, cnt=0.
//   - Ack in IDLE is ignored. Vld when Rdy=0 is ignored; there is no buffering.
//  DRIVE:
//   - D holds the one-hot value stable; Y/Vld changes have no effect.
//   - Ack=1 at edge: next cycle state=IDLE, D=0, Rdy=1, Busy=0, Done=1, Last=captured code.
//   - Else if cnt==TIMEOUT-1: same release, but Tout=1 instead of Done.
//   - Else cnt<=cnt+1.
//   - Ack and timeout on the same edge: Ack wins (Done=1, Tout=0).
//  Timing:
//   - Latency from accept edge to D valid: 1 cycle.
//   - Max grant length: TIMEOUT cycles.
//   - Done and Tout are each high for exactly 1 cycle, never both.
//   - Min spacing between accepts: 2 edges; a new accept is possible on the edge after the return to IDLE.
//  Width rules:
//   - cnt width = $clog2(TIMEOUT); cnt never wraps, because release occurs at TIMEOUT-1.
//   - D has exactly one bit set in DRIVE and is all-zero otherwise.
// TESTING
//  1. Reset: hold rst 3 cycles with Vld=1, Y=5 -> D=0, Rdy=0; after release Rdy=1, no grant taken while rst=1.
//  2. Full decode sweep: Y=0..7, Vld 1 cycle each, Ack 2 cycles after D rises.
//     -> D=8'h01,02,04,...,80 in turn; Done pulses 8 times; Last tracks Y.
//  3. Timeout: Y=3, no Ack -> D=8'h08 for exactly 16 cycles, then D=0, Tout=1 for 1 cycle, Last=3, Rdy=1.
//  4. Ack on the timeout edge (cnt=15) -> Done=1, Tout=0.
//  5. Vld held high with Y changing during DRIVE -> D unchanged, no extra accept.
//     Ack in IDLE has no effect.
//  6. rst asserted mid-DRIVE (Y=6) -> D=0 next cycle, Done=Tout=0, Last=0.

Source files
------------

// File: rtl/decoder_3x8_hs.sv
// Registered N:2**N grant decoder with valid/ready accept and
// per-grant acknowledge or timeout release.
module decoder_3x8_hs #(
  parameter int N       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      Y,
  input  logic              Vld,
  output logic              Rdy,
  output logic [2**N-1:0]   D,
  input  logic              Ack,
  output logic              Busy,
  output logic              Done,
  output logic              Tout,
  output logic [N-1:0]      Last
);

  localparam int W  = 2**N;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    DRIVE
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    d_q, d_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tout_q, tout_d;
  logic [N-1:0]    last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        d_d    = '0;
        busy_d = 1'b0;
        // Rdy is low on the first cycle out of reset, so Vld is ignored there
        if (rdy_q && Vld) begin
          state_d = DRIVE;
          code_d  = Y;
          cnt_d   = '0;
          d_d     = ONE << Y;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (Ack || cnt_q == CNT_MAX) begin
          state_d = IDLE;
          d_d     = '0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          last_d  = code_q;
          cnt_d   = '0;
          done_d  = Ack;
          tout_d  = !Ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Rdy  = rdy_q;
  assign D    = d_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Tout = tout_q;
  assign Last = last_q;

endmodule

// File: tb/tb_decoder_3x8_hs.sv
// Bench for decoder_3x8_hs: directed scenarios plus a random run
// against a transaction-level grant model.
module tb_decoder_3x8_hs;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] Y   = '0;
  logic       Vld = 1'b0;
  logic       Ack = 1'b0;
  logic       Rdy;
  logic [7:0] D;
  logic       Busy;
  logic       Done;
  logic       Tout;
  logic [2:0] Last;

  int checks = 0;
  int errors = 0;

  // model: is a grant open, which line, how many cycles it has been driven
  bit m_act  = 0;
  int m_code = 0;
  int m_age  = 0;
  bit m_rdy  = 0;
  bit m_done = 0;
  bit m_tout = 0;
  int m_last = 0;

  decoder_3x8_hs #(.N(3), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .Y   (Y),
    .Vld (Vld),
    .Rdy (Rdy),
    .D   (D),
    .Ack (Ack),
    .Busy(Busy),
    .Done(Done),
    .Tout(Tout),
    .Last(Last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_d();
    return m_act ? 8'(2 ** m_code) : 8'h00;
  endfunction

  task automatic step();
    m_done = 0;
    m_tout = 0;
    if (rst) begin
      m_act = 0; m_code = 0; m_age = 0;
      m_rdy = 0; m_last = 0;
    end else if (m_act) begin
      if (Ack || m_age + 1 == TIMEOUT) begin
        m_act  = 0;
        m_rdy  = 1;
        m_last = m_code;
        m_done = Ack;
        m_tout = !Ack;
      end else begin
        m_age++;
      end
    end else if (m_rdy && Vld) begin
      m_act = 1; m_code = int'(Y); m_age = 0; m_rdy = 0;
    end else begin
      m_rdy = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; Vld = 1; Y = 3'd5; Ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (D !== 8'h00) begin errors++; $display("FAIL reset_D got %h exp 00", D); end
      checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL reset_Rdy got %b exp 0", Rdy); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_Busy got %b exp 0", Busy); end
      checks++; if (Last !== 3'd0) begin errors++; $display("FAIL reset_Last got %0d exp 0", Last); end
    end
    rst = 0;
    step();
    Vld = 0;
    checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL rel_Rdy got %b exp 1", Rdy); end
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL rel_D got %h exp 00", D); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rel_Busy got %b exp 0", Busy); end
  endtask

  task automatic test_sweep();
    int dones = 0;
    for (int y = 0; y < 8; y++) begin
      Vld = 1; Y = 3'(y);
      step();
      Vld = 0;
      checks++; if (D !== 8'(1 << y)) begin errors++; $display("FAIL sweep_D y=%0d got %h exp %h", y, D, 8'(1 << y)); end
      checks++; if (Busy !== 1'b1 || Rdy !== 1'b0) begin errors++; $display("FAIL sweep_busy y=%0d got %b%b exp 10", y, Busy, Rdy); end
      step();
      step();
      Ack = 1;
      step();
      Ack = 0;
      if (Done === 1'b1) dones++;
      checks++; if (Last !== 3'(y)) begin errors++; $display("FAIL sweep_Last got %0d exp %0d", Last, y); end
      checks++; if (D !== 8'h00 || Rdy !== 1'b1 || Tout !== 1'b0) begin errors++; $display("FAIL sweep_rel y=%0d got D=%h Rdy=%b Tout=%b exp 00 1 0", y, D, Rdy, Tout); end
    end
    checks++; if (dones != 8) begin errors++; $display("FAIL sweep_dones got %0d exp 8", dones); end
  endtask

  task automatic test_timeout();
    int held = 0;
    Vld = 1; Y = 3'd3;
    step();
    Vld = 0;
    for (int i = 0; i < 20 && D === 8'h08; i++) begin
      held++;
      checks++; if (Tout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", Tout); end
      step();
    end
    checks++; if (held != TIMEOUT) begin errors++; $display("FAIL to_len got %0d exp %0d", held, TIMEOUT); end
    checks++; if (D !== 8'h00 || Tout !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL to_rel got D=%h Tout=%b Done=%b exp 00 1 0", D, Tout, Done); end
    checks++; if (Last !== 3'd3 || Rdy !== 1'b1) begin errors++; $display("FAIL to_last got Last=%0d Rdy=%b exp 3 1", Last, Rdy); end
    step();
    checks++; if (Tout !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", Tout); end
  endtask

  task automatic test_ack_at_timeout();
    Vld = 1; Y = 3'd1;
    step();
    Vld = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    checks++; if (D !== 8'h02) begin errors++; $display("FAIL aat_hold got %h exp 02", D); end
    Ack = 1;
    step();
    Ack = 0;
    checks++; if (Done !== 1'b1 || Tout !== 1'b0) begin errors++; $display("FAIL aat_win got Done=%b Tout=%b exp 1 0", Done, Tout); end
    checks++; if (Last !== 3'd1 || D !== 8'h00) begin errors++; $display("FAIL aat_rel got Last=%0d D=%h exp 1 00", Last, D); end
  endtask

  task automatic test_hold_vld();
    Vld = 1; Y = 3'd2;
    step();
    for (int i = 0; i < 5; i++) begin
      Y = 3'($urandom_range(0, 7));
      step();
      checks++; if (D !== 8'h04 || Rdy !== 1'b0) begin errors++; $display("FAIL hold_D got %h Rdy=%b exp 04 0", D, Rdy); end
    end
    Vld = 0; Ack = 1;
    step();
    checks++; if (Done !== 1'b1 || Last !== 3'd2) begin errors++; $display("FAIL hold_done got Done=%b Last=%0d exp 1 2", Done, Last); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (Done !== 1'b0 || D !== 8'h00 || Rdy !== 1'b1 || Last !== 3'd2) begin errors++; $display("FAIL idle_ack got Done=%b D=%h Rdy=%b Last=%0d exp 0 00 1 2", Done, D, Rdy, Last); end
    end
    Ack = 0;
  endtask

  task automatic test_mid_rst();
    Vld = 1; Y = 3'd6;
    step();
    Vld = 0;
    step();
    checks++; if (D !== 8'h40) begin errors++; $display("FAIL mr_D got %h exp 40", D); end
    rst = 1;
    step();
    checks++; if (D !== 8'h00 || Done !== 1'b0 || Tout !== 1'b0) begin errors++; $display("FAIL mr_abort got D=%h Done=%b Tout=%b exp 00 0 0", D, Done, Tout); end
    checks++; if (Last !== 3'd0 || Busy !== 1'b0 || Rdy !== 1'b0) begin errors++; $display("FAIL mr_state got Last=%0d Busy=%b Rdy=%b exp 0 0 0", Last, Busy, Rdy); end
    rst = 0;
    step();
    checks++; if (Rdy !== 1'b1 || Done !== 1'b0 || Tout !== 1'b0) begin errors++; $display("FAIL mr_after got Rdy=%b Done=%b Tout=%b exp 1 0 0", Rdy, Done, Tout); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      Vld = ($urandom_range(0, 2) != 0);
      Y   = 3'($urandom_range(0, 7));
      Ack = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (D !== m_d() || Rdy !== m_rdy || Busy !== m_act ||
          Done !== m_done || Tout !== m_tout || Last !== 3'(m_last)) begin
        errors++;
        if (bad < 10) $display("FAIL rand cyc=%0d got D=%h R=%b B=%b Dn=%b T=%b L=%0d exp D=%h R=%b B=%b Dn=%b T=%b L=%0d",
          i, D, Rdy, Busy, Done, Tout, Last, m_d(), m_rdy, m_act, m_done, m_tout, m_last);
        bad++;
      end
      checks++; if ((Done & Tout) !== 1'b0) begin errors++; $display("FAIL rand_both cyc=%0d got 1 exp 0", i); end
    end
    Vld = 0; Ack = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_timeout();
    test_ack_at_timeout();
    test_hold_vld();
    test_mid_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
